// File: rtl/trng_vn_conditioner.sv
// -----------------------------------------------------------------------------
// trng_vn_conditioner
//
// Conditioning stage for the ring-oscillator TRNG. The raw bit is sampled every
// (div+1) cycles. Sample pairs go through a von Neumann extractor (10 -> 1,
// 01 -> 0, 00/11 discarded). Extracted bits are packed MSB-first into bytes and
// queued in a small FIFO that the register logic pops.
//
// Optional feature (macro TRNG_RCT_EN): a repetition-count health test. When
// RCT_LIMIT consecutive samples are equal, fail is set. While fail is set, no
// bytes are produced. Without the macro, fail is tied low.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   en           conditioner enable; low clears divider, pair FSM and packer
//   div          sample period minus one
//   raw_bit      synchronised raw entropy bit, observed on strobe cycles only
//   rd_pop       one-cycle strobe, pops the FIFO head (ignored when empty)
//   clr_fail     clears the overflow and fail sticky flags and the run counter
//   data_out     FIFO head byte, 0x00 when empty
//   fifo_level   number of entries held
//   empty, full  FIFO status
//   overflow     sticky: a byte was dropped because the FIFO was full
//   fail         sticky: health-test failure
// -----------------------------------------------------------------------------
module trng_vn_conditioner #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 8,
   parameter int RCT_LIMIT  = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [DIV_W-1:0]            div,
   input  logic                        raw_bit,
   input  logic                        rd_pop,
   input  logic                        clr_fail,
   output logic [7:0]                  data_out,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        empty,
   output logic                        full,
   output logic                        overflow,
   output logic                        fail
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       RCT_LIMIT < 2 || RCT_LIMIT > 255) begin : g_param_check
      $error("trng_vn_conditioner: illegal FIFO_DEPTH or RCT_LIMIT");
   end

   typedef enum logic {IDLE, HAVE1} pair_state_e;

   // Sampler
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             strobe;

   // Pair FSM and packer
   pair_state_e state_q, state_d;
   logic        b0_q, b0_d;
   logic [6:0]  acc_q, acc_d;
   logic [2:0]  nbits_q, nbits_d;
   logic        push;
   logic [7:0]  push_byte;

   // FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    dout_q, dout_d;
   logic          empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
   logic          pop_ok, wr_en, drop;

   // Health-test hold: blocks the extractor while a failure is pending
   logic hold;

   // -------------------------------------------------------------------------
   // Sampler: strobe when the counter matches div; a new div value is picked
   // up by the next compare.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      cnt_d  = cnt_q;
      strobe = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == div) begin
         strobe = 1'b1;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Pair FSM and byte packer. acc collects the first seven bits of a byte
   // (first bit ends up in acc[6]); the eighth bit completes the byte, which
   // is pushed in the same cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      b0_d      = b0_q;
      acc_d     = acc_q;
      nbits_d   = nbits_q;
      push      = 1'b0;
      push_byte = {acc_q, b0_q};
      if (!en || hold) begin
         state_d = IDLE;
         b0_d    = 1'b0;
         acc_d   = '0;
         nbits_d = '0;
      end else if (strobe) begin
         case (state_q)
            IDLE: begin
               b0_d    = raw_bit;
               state_d = HAVE1;
            end
            HAVE1: begin
               state_d = IDLE;
               if (raw_bit != b0_q) begin
                  if (nbits_q == 3'd7) begin
                     push    = 1'b1;
                     acc_d   = '0;
                     nbits_d = '0;
                  end else begin
                     acc_d   = {acc_q[5:0], b0_q};
                     nbits_d = nbits_q + 3'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FIFO control. A push into a full FIFO still lands if a pop frees a slot
   // in the same cycle; otherwise the byte is dropped and overflow is set.
   // data_out is registered, so its next value is the head after this edge.
   // -------------------------------------------------------------------------
   always_comb begin
      pop_ok   = rd_pop && (level_q != '0);
      wr_en    = push && ((level_q != DEPTH_L) || pop_ok);
      drop     = push && !wr_en;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;

      level_d = level_q;
      if (wr_en && !pop_ok) begin
         level_d = level_q + LW'(1);
      end else if (!wr_en && pop_ok) begin
         level_d = level_q - LW'(1);
      end
      empty_d = (level_d == '0);
      full_d  = (level_d == DEPTH_L);

      // The new head is the byte being written only when the FIFO drains to
      // exactly that slot in this cycle.
      if (level_d == '0) begin
         dout_d = 8'h00;
      end else if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
         dout_d = push_byte;
      end else begin
         dout_d = mem_q[rd_ptr_d];
      end

      // Set wins over clear.
      ovf_d = drop ? 1'b1 : (clr_fail ? 1'b0 : ovf_q);
   end

   // -------------------------------------------------------------------------
   // Repetition-count health test
   // -------------------------------------------------------------------------
`ifdef TRNG_RCT_EN
   localparam logic [7:0] LIMIT_L = 8'(RCT_LIMIT);

   logic [7:0] run_q, run_d, run_next;
   logic       last_q, last_d;
   logic       fail_q, fail_d, fail_set;

   // run_q == 0 means no sample seen since reset or clr_fail.
   always_comb begin
      run_next = run_q;
      last_d   = last_q;
      if (strobe) begin
         last_d = raw_bit;
         if ((run_q == 8'd0) || (raw_bit != last_q)) begin
            run_next = 8'd1;
         end else if (run_q != LIMIT_L) begin
            run_next = run_q + 8'd1;
         end
      end
      fail_set = strobe && (run_next == LIMIT_L);
      run_d    = (clr_fail && !fail_set) ? 8'd0 : run_next;
      fail_d   = fail_set ? 1'b1 : (clr_fail ? 1'b0 : fail_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q  <= 8'd0;
         last_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         last_q <= last_d;
         fail_q <= fail_d;
      end
   end

   assign hold = fail_q;
   assign fail = fail_q;
`else
   assign hold = 1'b0;
   assign fail = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its _d value from before the edge, independent of order.
      if (!rst_n) begin
         cnt_q    <= '0;
         state_q  <= IDLE;
         b0_q     <= 1'b0;
         acc_q    <= '0;
         nbits_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= 8'h00;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         b0_q     <= b0_d;
         acc_q    <= acc_d;
         nbits_q  <= nbits_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers and level define which
   // entries are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[wr_ptr_q] <= push_byte;
      end
   end

   assign data_out   = dout_q;
   assign fifo_level = level_q;
   assign empty      = empty_q;
   assign full       = full_q;
   assign overflow   = ovf_q;

endmodule

// File: doc/trng_vn_conditioner.md
# trng_vn_conditioner

Downstream conditioning stage for the ring-oscillator TRNG in the TinyQV TRNG peripheral. It samples the raw entropy bit at a programmable rate and removes bias with a von Neumann extractor. Extracted bits are packed into bytes and buffered in a small FIFO, which the peripheral register logic pops. An optional repetition-count health test flags a stuck source.

## Interface

Parameters:

- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2
- DIV_W, 8, width of the sample divider
- RCT_LIMIT, 32, consecutive identical raw samples that declare a failure; 2..255

Ports:

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  conditioner enable
- div  in  DIV_W  sample period minus one
- raw_bit  in  1  raw TRNG bit, already synchronised
- rd_pop  in  1  pop FIFO head, one-cycle strobe
- clr_fail  in  1  clear fail and overflow sticky flags
- data_out  out  8  FIFO head byte; 0x00 when empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- empty  out  1  fifo_level==0
- full  out  1  fifo_level==FIFO_DEPTH
- overflow  out  1  sticky; a byte was dropped
- fail  out  1  sticky health-test failure

## Operation

- **Reset values:** data_out 0x00, fifo_level 0, empty 1, full 0, overflow 0, fail 0. The divider counter, pair FSM, packer and RCT counter are all cleared.
- **Sampler:**
  - cnt counts 0..div. Strobe s fires when en && cnt==div, and cnt then wraps to 0.
  - div=0 gives a strobe every cycle.
  - en=0 holds cnt at 0 and clears the pair FSM and packer. FIFO contents are retained.
  - A change of div takes effect at the next compare.
- **Pair FSM:**
  - States: IDLE, HAVE1.
  - IDLE: on s, latch b0=raw_bit and go to HAVE1.
  - HAVE1: on s, if raw_bit!=b0, emit bit b0 (pattern 10 emits 1, 01 emits 0). Pairs 00 and 11 are discarded. Go to IDLE.
- **Packer:**
  - On each emitted bit, acc <= {acc[6:0], bit} and nbits++. The first emitted bit ends up as bit 7 of the byte.
  - When the 8th bit arrives, {acc[6:0], bit} is pushed that same cycle and nbits resets to 0.
- **FIFO:**
  - Push when full: the byte is dropped and overflow is set. fifo_level stays unchanged.
  - rd_pop when empty: ignored.
  - Push and pop in the same cycle: both happen and level is unchanged. This holds even when full, where no drop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- **clr_fail:** clears overflow and fail, and resets the RCT counter. If clr_fail coincides with a new failure condition, the set wins.
- **Health test:** see Configuration.

## Timing

- All outputs are registered.
- Byte latency: a push at edge N makes empty=0 and data_out valid after edge N. This is one cycle after the strobe carrying the last sample.
- Pop: rd_pop high at edge N updates data_out, fifo_level and empty after edge N.
- raw_bit is only observed on strobe cycles. Values between strobes are ignored.
- If rst_n is asserted mid-byte or mid-pair, the partial state is discarded.

## Configuration

- Macro TRNG_RCT_EN.
- **Defined:**
  - A run counter tracks consecutive equal raw samples on strobes. It resets to 1 on a change and saturates at RCT_LIMIT.
  - When the run reaches RCT_LIMIT, fail is set on that edge.
  - While fail=1, no FIFO pushes occur and the pair FSM and packer are held cleared.
  - clr_fail resumes operation on the next strobe.
- **Undefined:** no run counter. fail is tied to 0, and clr_fail clears overflow only.

## Test plan

1. **Packing:** div=0, en=1, raw pairs 10,01,10,10,01,01,10,01 (16 samples). Expect one push with data_out=0xB2, and empty falling 1 cycle after the 16th sample.
2. **Discarded pairs:** only 00/11 pairs for 64 samples. Expect empty to stay 1 and fifo_level to stay 0.
3. **Overflow and drain:** FIFO_DEPTH=4, generate 5 bytes 0x01..0x05. Expect full=1, level=4, overflow=1. Four pops return 0x01..0x04 and empty=1. A simultaneous push and pop at full causes no drop.
4. **Divider:** div=3, raw_bit toggling every cycle. Expect strobes every 4th cycle and the sampled stream to be constant. With TRNG_RCT_EN and RCT_LIMIT=32, fail rises on the 32nd strobe.
5. **Health-test recovery:** TRNG_RCT_EN defined, raw_bit stuck at 1. Expect fail=1 and no pushes. Pulse clr_fail, then apply an alternating-pair stream; expect fail=0 and bytes to resume.
6. **Reset mid-byte:** after 5 emitted bits, pulse rst_n low for 1 cycle. Expect all outputs at reset values. The next 8 emitted bits form a clean byte, with no stale bits.
